data_mem_responder: RTL

Memory-side responder for the multi-cycle computer's data path. It sits opposite the controller's memory-request outputs (read-not-write, memory select, address, write data) and services each request after a configurable number of wait states. It holds the data storage, performs word or byte-lane accesses, and returns a single-cycle response pulse carrying read data or an error flag. This lets the controller FSM model slow memory instead of assuming a zero-latency RAM.

---
 rtl/data_mem_responder_pkg.sv | 33 +++
 rtl/data_mem_array.sv | 35 +++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared widths, state encoding and mem_select codes
package data_mem_responder_pkg;

  localparam int DATA_W_DEF  = 24;
  localparam int ADDR_W_DEF  = 24;
  localparam int DEPTH_DEF   = 1024;
  localparam int WAIT_DEF    = 2;
  localparam int LANE_W      = 8;
  localparam int NUM_LANES   = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  localparam logic [1:0] MEM_SEL_WORD = 2'b00;
  localparam logic [1:0] MEM_SEL_B0   = 2'b01;
  localparam logic [1:0] MEM_SEL_B1   = 2'b10;
  localparam logic [1:0] MEM_SEL_B2   = 2'b11;

  // Lane-enable mask for a store: all lanes for a word, one lane otherwise.
  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [1:0] sel);
    case (sel)
      MEM_SEL_B0: lane_mask = 3'b001;
      MEM_SEL_B1: lane_mask = 3'b010;
      MEM_SEL_B2: lane_mask = 3'b100;
      default:    lane_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word storage with lane-masked write and registered read
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DW    = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = 10
) (
  input  logic                 clock,
  input  logic                 i_we,
  input  logic [NUM_LANES-1:0] i_lane_en,
  input  logic [IDX_W-1:0]     i_waddr,
  input  logic [DW-1:0]        i_wdata,
  input  logic [IDX_W-1:0]     i_raddr,
  output logic [DW-1:0]        o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Lane-masked store and registered read; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (i_lane_en[k]) begin
          r_mem[i_waddr][LANE_W*k +: LANE_W] <= i_wdata[LANE_W*k +: LANE_W];
        end
      end
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated memory responder for the controller data path
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_BUS_WIDTH    = DATA_W_DEF,
  parameter int ADDRESS_BUS_WIDTH = ADDR_W_DEF,
  parameter int DEPTH             = DEPTH_DEF,
  parameter int WAIT_STATES       = WAIT_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         read_not_write,
  input  logic [1:0]                   mem_select,
  input  logic [ADDRESS_BUS_WIDTH-1:0] address,
  input  logic [DATA_BUS_WIDTH-1:0]    write_data,
  output logic                         rsp_valid,
  output logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic                         rsp_error,
  output logic                         busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  state_t                         r_state;
  logic [3:0]                     r_wait_cnt;
  logic                           r_req_rnw;
  logic [1:0]                     r_req_sel;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_req_addr;
  logic [DATA_BUS_WIDTH-1:0]      r_req_wdata;
  logic                           r_req_ready;
  logic                           r_rsp_valid;
  logic                           r_rsp_error;
  logic                           r_busy;
  logic [DATA_BUS_WIDTH-1:0]      r_read_data;

  logic                           w_accept;
  logic                           w_req_err;
  logic [IDX_W-1:0]               w_rd_idx;
  logic                           w_wr_en;
  logic [NUM_LANES-1:0]           w_wr_mask;
  logic [DATA_BUS_WIDTH-1:0]      w_wr_data;
  logic [DATA_BUS_WIDTH-1:0]      w_arr_rdata;
  logic [DATA_BUS_WIDTH-1:0]      w_load_data;

  assign w_accept  = req_valid && r_req_ready;
  assign w_req_err = (r_req_addr >= ADDRESS_BUS_WIDTH'(DEPTH));

  // While idle the array prefetches the incoming address so a zero-wait build
  // has the word ready in ACCESS; afterwards it tracks the captured address.
  assign w_rd_idx  = (r_state == ST_IDLE) ? address[IDX_W-1:0] : r_req_addr[IDX_W-1:0];
  assign w_wr_en   = (r_state == ST_ACCESS) && !r_req_rnw && !w_req_err;
  assign w_wr_mask = lane_mask(r_req_sel);
  assign w_wr_data = (r_req_sel == MEM_SEL_WORD) ? r_req_wdata
                                                 : {NUM_LANES{r_req_wdata[LANE_W-1:0]}};

  data_mem_array #(
    .DW    (DATA_BUS_WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock     (clock),
    .i_we      (w_wr_en),
    .i_lane_en (w_wr_mask),
    .i_waddr   (r_req_addr[IDX_W-1:0]),
    .i_wdata   (w_wr_data),
    .i_raddr   (w_rd_idx),
    .o_rdata   (w_arr_rdata)
  );

  // Lane select with zero extension; out-of-range reads return zero.
  always_comb begin
    w_load_data = '0;
    if (!w_req_err) begin
      case (r_req_sel)
        MEM_SEL_B0: w_load_data[LANE_W-1:0] = w_arr_rdata[0*LANE_W +: LANE_W];
        MEM_SEL_B1: w_load_data[LANE_W-1:0] = w_arr_rdata[1*LANE_W +: LANE_W];
        MEM_SEL_B2: w_load_data[LANE_W-1:0] = w_arr_rdata[2*LANE_W +: LANE_W];
        default:    w_load_data             = w_arr_rdata;
      endcase
    end
  end

  // Request FSM with wait counter, request capture and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_req_rnw   <= 1'b0;
      r_req_sel   <= '0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_busy      <= 1'b0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_rnw   <= read_not_write;
            r_req_sel   <= mem_select;
            r_req_addr  <= address;
            r_req_wdata <= write_data;
            r_wait_cnt  <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= ST_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        ST_ACCESS: begin
          r_state     <= ST_RESPOND;
          r_rsp_valid <= 1'b1;
          r_rsp_error <= w_req_err;
          if (r_req_rnw) begin
            r_read_data <= w_load_data;
          end
        end
        ST_RESPOND: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_error <= 1'b0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_error = r_rsp_error;
  assign busy      = r_busy;
  assign read_data = r_read_data;

endmodule
